// File: rtl/lsu_rmw.sv
// Load/store unit between the core memory stage and a word-only dmem.
// Sub-word stores are a read-modify-write because dmem has no byte enables.
module lsu_rmw #(
  parameter int DMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic        mem_re,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, RMW_RD, RMW_WR, ERR, RESP} state_t;

  localparam logic [31:0] LIM_B = 32'(DMEM_BYTES - 1);
  localparam logic [31:0] LIM_H = 32'(DMEM_BYTES - 2);
  localparam logic [31:0] LIM_W = 32'(DMEM_BYTES - 4);

  state_t      state;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] buf_q;

  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic illegal;
    logic mis;
    logic oor;
    illegal = 1'b0;
    mis     = 1'b0;
    oor     = 1'b0;
    case (f3)
      3'b000, 3'b100: oor = (addr > LIM_B);
      3'b001, 3'b101: begin mis = addr[0];          oor = (addr > LIM_H); end
      3'b010:         begin mis = (addr[1:0] != 2'b00); oor = (addr > LIM_W); end
      default:        illegal = 1'b1;
    endcase
    if (we && f3[2]) illegal = 1'b1;
    return illegal | mis | oor;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = 32'(b);
      3'b001:  r = 32'(h);
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] d,
                                              input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] m;
    m = w;
    if (f3[1:0] == 2'b00) m[8*a +: 8] = d[7:0];
    else if (a[1])        m[31:16]    = d[15:0];
    else                  m[15:0]     = d[15:0];
    return m;
  endfunction

  assign req_ready = (state == IDLE);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = (state == RMW_WR) ? buf_q : wdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      buf_q      <= 32'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
    end else begin
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          we_q     <= req_we;
          funct3_q <= req_funct3;
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          if (req_error(req_we, req_funct3, req_addr)) begin
            state <= ERR;
          end else if (!req_we) begin
            state  <= LOAD;
            mem_re <= 1'b1;
          end else if (req_funct3 == 3'b010) begin
            state  <= WRITE;
            mem_we <= 1'b1;
          end else begin
            state  <= RMW_RD;
            mem_re <= 1'b1;
          end
        end
        LOAD: begin
          resp_rdata <= load_ext(mem_rdata, funct3_q, addr_q[1:0]);
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        // buffer holds the already-merged word so RMW_WR only drives it out
        RMW_RD: begin
          buf_q  <= store_merge(mem_rdata, wdata_q, funct3_q, addr_q[1:0]);
          mem_we <= 1'b1;
          state  <= RMW_WR;
        end
        WRITE, RMW_WR: begin
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        ERR: begin
          resp_rdata <= 32'd0;
          resp_err   <= 1'b1;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
